// File: rtl/arb_req_queue.sv
// Request-side front end for the three-way Arbiter: per-client FIFOs drive the requests,
// and the granted client's head word goes out on one registered, source-tagged output bus.
module arb_req_queue #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              res,
   input  logic              wr_en0,
   input  logic              wr_en1,
   input  logic              wr_en2,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic [DATA_W-1:0] wr_data2,
   output logic              full0,
   output logic              full1,
   output logic              full2,
   output logic [ADDR_W:0]   level0,
   output logic [ADDR_W:0]   level1,
   output logic [ADDR_W:0]   level2,
   output logic              ovf0,
   output logic              ovf1,
   output logic              ovf2,
   output logic              req0,
   output logic              req1,
   output logic              req2,
   input  logic              grant0,
   input  logic              grant1,
   input  logic              grant2,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_src,
   output logic              gnt_err
);
   localparam int NCLI = 3;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   logic [NCLI-1:0]   wr_en_v, grant_v, full_v, ovf_v, push_v, pop_v;
   logic [DATA_W-1:0] wr_data_v [NCLI];
   logic [DATA_W-1:0] head_v    [NCLI];
   logic [ADDR_W:0]   count_v   [NCLI];

   assign wr_en_v      = {wr_en2, wr_en1, wr_en0};
   assign grant_v      = {grant2, grant1, grant0};
   assign wr_data_v[0] = wr_data0;
   assign wr_data_v[1] = wr_data1;
   assign wr_data_v[2] = wr_data2;

   genvar gi;
   generate
      for (gi = 0; gi < NCLI; gi++) begin : g_fifo
         logic [DATA_W-1:0] mem_q [DEPTH];
         logic [ADDR_W-1:0] wptr_q, rptr_q;
         logic [ADDR_W:0]   count_q, count_d;
         logic              ovf_q;

         // A push is judged against the pre-edge count, so a same-cycle pop never frees room for it.
         assign full_v[gi]  = (count_q == FULL_CNT);
         assign push_v[gi]  = wr_en_v[gi] && !full_v[gi];
         assign head_v[gi]  = mem_q[rptr_q];
         assign count_v[gi] = count_q;
         assign ovf_v[gi]   = ovf_q;

         always_comb begin
            count_d = count_q;
            if (push_v[gi] && !pop_v[gi]) begin
               count_d = count_q + 1'b1;
            end else if (pop_v[gi] && !push_v[gi]) begin
               count_d = count_q - 1'b1;
            end
         end

         always_ff @(posedge clk or posedge res) begin
            if (res) begin
               wptr_q  <= '0;
               rptr_q  <= '0;
               count_q <= '0;
               ovf_q   <= 1'b0;
            end else begin
               if (push_v[gi]) wptr_q <= wptr_q + 1'b1;
               if (pop_v[gi])  rptr_q <= rptr_q + 1'b1;
               count_q <= count_d;
               if (wr_en_v[gi] && full_v[gi]) ovf_q <= 1'b1;
            end
         end

         // Storage needs no reset: contents are only reachable through the reset pointers.
         always_ff @(posedge clk) begin
            if (push_v[gi]) mem_q[wptr_q] <= wr_data_v[gi];
         end
      end
   endgenerate

   logic              pop_found;
   logic [1:0]        sel_idx;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [1:0]        out_src_q, out_src_d;
   logic              gnt_err_q, gnt_err_d;

   // Lowest-index granted non-empty FIFO wins; grants to empty FIFOs are stale and ignored.
   always_comb begin
      pop_v     = '0;
      pop_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NCLI; i++) begin
         if (!pop_found && grant_v[i] && (count_v[i] != '0)) begin
            pop_v[i]  = 1'b1;
            pop_found = 1'b1;
            sel_idx   = 2'(i);
         end
      end
   end

   always_comb begin
      out_valid_d = pop_found;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      gnt_err_d   = gnt_err_q | ((grant_v & (grant_v - 1'b1)) != '0);
      if (pop_found) begin
         out_data_d = head_v[sel_idx];
         out_src_d  = sel_idx;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         gnt_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         gnt_err_q   <= gnt_err_d;
      end
   end

   assign full0     = full_v[0];
   assign full1     = full_v[1];
   assign full2     = full_v[2];
   assign level0    = count_v[0];
   assign level1    = count_v[1];
   assign level2    = count_v[2];
   assign ovf0      = ovf_v[0];
   assign ovf1      = ovf_v[1];
   assign ovf2      = ovf_v[2];
   assign req0      = (count_v[0] != '0);
   assign req1      = (count_v[1] != '0);
   assign req2      = (count_v[2] != '0);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign gnt_err   = gnt_err_q;
endmodule
